hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Parametrised hazard controller for the 5-stage RV32 pipeline. It combinationally resolves operand forwarding for the execute stage. It holds fetch and decode for load-use hazards, with a configurable load latency, and flushes on taken branches/jumps. A register scoreboard tracks long-latency writebacks (mul/div unit) and stalls decode until the destination register is retired.

Parameters:
REG_ADDR_W, 5, register index width; register file holds 2**REG_ADDR_W entries
LOAD_USE_CYCLES, 1, decode stall cycles per load-use hazard (1..7)
SCOREBOARD_EN, 1, 1 enables long-latency scoreboard; 0 ties scoreboard to zero
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
rs1_d, rs2_d  in  REG_ADDR_W  decode-stage source registers
rs1_e, rs2_e, rd_e  in  REG_ADDR_W  execute-stage sources/destination
rd_m, rd_w  in  REG_ADDR_W  memory/writeback destinations
reg_write_m, reg_write_w  in  1  memory/writeback write enables
result_src_e  in  2  execute result select; bit0=1 means load
pc_src_e  in  1  taken branch/jump resolved in execute
long_issue_e  in  1  execute instr dispatched to long-latency unit, dest rd_e
long_done  in  1  long-latency unit retiring a result
long_done_rd  in  REG_ADDR_W  register retired by long_done
forward_ae, forward_be  out  2  forward_a_t / forward_b_t select
stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls
sb_busy  out  1  any scoreboard bit set
stall_count  out  PERF_W  saturating count of stalled cycles

Behaviour:
- All clocking is on the clk rising edge. rst_n low asynchronously clears the scoreboard, the load counter and stall_count.
- While rst_n is low: stall/flush outputs are 0, forwards are *_EXECUTE_RD1/RD2, sb_busy=0.
- Forwarding is purely combinational, no clock latency.
- forward_ae:
  - MEMORY_ALU_RESULT if rs1_e!=0, rs1_e==rd_m and reg_write_m.
  - Otherwise WRITE_BACK_RESULT if rs1_e!=0, rs1_e==rd_w and reg_write_w.
  - Otherwise EXECUTE_RD1.
- forward_be: same rules using rs2_e; default EXECUTE_RD2.
- Memory has priority over writeback. x0 is never forwarded.
- Load-use hazard: lu_hit = result_src_e[0] & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- Load stall counter lu_cnt (3 bits, reset 0):
  - When lu_hit and lu_cnt==0, it loads LOAD_USE_CYCLES-1 at the edge.
  - While lu_cnt!=0 it decrements each cycle.
  - lu_stall = lu_hit | (lu_cnt!=0).
  - With LOAD_USE_CYCLES=1 the stall lasts exactly one cycle and the counter never leaves 0.
- Scoreboard sb[2**REG_ADDR_W-1:0], reset 0:
  - Set: at the edge, if long_issue_e & rd_e!=0 & !flush_e, set bit rd_e.
  - Clear: at the edge, if long_done, clear bit long_done_rd.
  - If set and clear target the same register in the same cycle, set wins (a newer writer is in flight).
  - Bit 0 is always 0.
- sb_stall = SCOREBOARD_EN & (sb[rs1_d] | sb[rs2_d] | (long_done & 0)).
  - Combinational on current sb state; no bypass of same-cycle long_done.
- hold = lu_stall | sb_stall.
- Control outputs:
  - stall_f = stall_d = hold & !pc_src_e.
  - flush_e = hold | pc_src_e.
  - flush_d = pc_src_e.
- Branch priority: pc_src_e clears lu_cnt to 0 at the edge; squashed loads do not extend the stall. Scoreboard bits are not cleared by a flush, because the long op is already dispatched.
- sb_busy = |sb.
- stall_count increments when stall_f=1 and saturates at all-ones.

Test Plan:
- Forwarding priority: rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_ae=MEMORY_ALU_RESULT. Drop reg_write_m -> WRITE_BACK_RESULT. Repeat with rs1_e=0 -> EXECUTE_RD1.
- Load-use with LOAD_USE_CYCLES=3: result_src_e=2'b01, rd_e=7, rs2_d=7 for one cycle, then a bubble -> stall_f/stall_d/flush_e high for exactly 3 cycles; stall_count=3.
- Branch during load stall: start the LOAD_USE_CYCLES=3 stall, assert pc_src_e on stall cycle 2 -> that cycle flush_d=flush_e=1, stall_f=0; next cycle all controls 0.
- Scoreboard: long_issue_e with rd_e=9; next cycle rs1_d=9 -> stall_d=1, sb_busy=1 until long_done with long_done_rd=9. One cycle after retire: stall_d=0, sb_busy=0.
- Same-cycle set/clear: sb[4] set; long_done rd=4 together with long_issue_e rd_e=4 -> sb[4] remains 1. Also: long_issue_e with rd_e=0 -> no bit set.
- Async reset mid-stall: assert rst_n=0 between clock edges during a load stall -> outputs drop to 0 immediately; after release, no residual stall and stall_count=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: execute-stage forwarding,
// load-use and long-latency scoreboard stalls, and branch flushes.
module hazard_ctrl #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_CYCLES = 1,
    parameter bit SCOREBOARD_EN   = 1'b1,
    parameter int PERF_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic [1:0]            result_src_e,
    input  logic                  pc_src_e,
    input  logic                  long_issue_e,
    input  logic                  long_done,
    input  logic [REG_ADDR_W-1:0] long_done_rd,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  sb_busy,
    output logic [PERF_W-1:0]     stall_count
);

    typedef enum logic [1:0] {
        EXECUTE_RD         = 2'b00,
        WRITE_BACK_RESULT  = 2'b01,
        MEMORY_ALU_RESULT  = 2'b10
    } forward_t;

    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);

    logic [2:0]          lu_cnt;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic                lu_hit, lu_stall, sb_stall, hold;
    logic                unused_src;

    assign unused_src = result_src_e[1];

    function automatic forward_t fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (rs != '0 && rs == rd_m && reg_write_m)
            return MEMORY_ALU_RESULT;
        else if (rs != '0 && rs == rd_w && reg_write_w)
            return WRITE_BACK_RESULT;
        else
            return EXECUTE_RD;
    endfunction

    // Outputs are gated by rst_n so the pipeline sees a quiet controller during reset
    always_comb begin
        forward_ae = EXECUTE_RD;
        forward_be = EXECUTE_RD;
        if (rst_n) begin
            forward_ae = fwd_sel(rs1_e);
            forward_be = fwd_sel(rs2_e);
        end
    end

    assign lu_hit   = result_src_e[0] && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign lu_stall = lu_hit || lu_cnt != 3'd0;
    assign sb_stall = SCOREBOARD_EN && (sb[rs1_d] || sb[rs2_d]);
    assign hold     = rst_n && (lu_stall || sb_stall);

    assign stall_f = hold && !pc_src_e;
    assign stall_d = stall_f;
    assign flush_e = hold || (rst_n && pc_src_e);
    assign flush_d = rst_n && pc_src_e;
    assign sb_busy = |sb;

    // A taken branch squashes the in-flight load, so its remaining stall is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lu_cnt <= 3'd0;
        else if (pc_src_e)
            lu_cnt <= 3'd0;
        else if (lu_cnt != 3'd0)
            lu_cnt <= lu_cnt - 3'd1;
        else if (lu_hit)
            lu_cnt <= LU_RELOAD;
    end

    // Set is applied after clear: a same-cycle reissue to the retiring register stays busy
    always_comb begin
        sb_next = sb;
        if (long_done)
            sb_next[long_done_rd] = 1'b0;
        if (long_issue_e && rd_e != '0 && !flush_e)
            sb_next[rd_e] = 1'b1;
        sb_next[0] = 1'b0;
    end

    generate
        if (SCOREBOARD_EN) begin : g_sb
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sb <= '0;
                else
                    sb <= sb_next;
            end
        end else begin : g_no_sb
            assign sb = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_f && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl with a 3-cycle load-use stall.
module tb_hazard_ctrl;
    localparam int AW = 5;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, long_done_rd;
    logic          reg_write_m, reg_write_w, pc_src_e, long_issue_e, long_done;
    logic [1:0]    result_src_e;
    logic [1:0]    forward_ae, forward_be;
    logic          stall_f, stall_d, flush_d, flush_e, sb_busy;
    logic [PW-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W(AW), .LOAD_USE_CYCLES(3), .SCOREBOARD_EN(1'b1), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .pc_src_e(pc_src_e), .long_issue_e(long_issue_e),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .sb_busy(sb_busy), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        rd_m = '0; rd_w = '0; reg_write_m = 0; reg_write_w = 0;
        result_src_e = 2'b00; pc_src_e = 0; long_issue_e = 0;
        long_done = 0; long_done_rd = '0;
    endtask

    task automatic ctl(input string tag, input logic sf, input logic fd, input logic fe);
        chk({tag, ".stall_f"}, 32'(stall_f), 32'(sf));
        chk({tag, ".stall_d"}, 32'(stall_d), 32'(sf));
        chk({tag, ".flush_d"}, 32'(flush_d), 32'(fd));
        chk({tag, ".flush_e"}, 32'(flush_e), 32'(fe));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        // forwarding and hazard conditions present while held in reset
        rs1_e = 5; rd_m = 5; reg_write_m = 1;
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7; pc_src_e = 1;
        #12;
        chk("rst.fwd_a", 32'(forward_ae), 32'd0);
        ctl("rst", 0, 0, 0);
        chk("rst.sb_busy", 32'(sb_busy), 32'd0);
        chk("rst.count", stall_count, 32'd0);
        idle();
        #2 rst_n = 1;
        next_cyc();

        // forwarding priority
        rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
        #2 chk("fwd.mem", 32'(forward_ae), 32'd2);
        reg_write_m = 0;
        #2 chk("fwd.wb", 32'(forward_ae), 32'd1);
        rs1_e = 0; reg_write_m = 1;
        #2 chk("fwd.x0", 32'(forward_ae), 32'd0);
        rs2_e = 3; rd_w = 3; rd_m = 5;
        #2 chk("fwd.b_wb", 32'(forward_be), 32'd1);
        rs2_e = 5;
        #1 chk("fwd.b_mem", 32'(forward_be), 32'd2);
        idle();

        // load-use, 3 stall cycles
        next_cyc();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #2 ctl("lu.c1", 1, 0, 1);
        next_cyc();
        result_src_e = 2'b00; rd_e = 0;
        #2 ctl("lu.c2", 1, 0, 1);
        next_cyc();
        #2 ctl("lu.c3", 1, 0, 1);
        next_cyc();
        #2 ctl("lu.c4", 0, 0, 0);
        chk("lu.count", stall_count, 32'd3);

        // branch resolved during stall cycle 2
        next_cyc();
        result_src_e = 2'b01; rd_e = 7; rs2_d = 7;
        #2 ctl("br.c1", 1, 0, 1);
        next_cyc();
        result_src_e = 2'b00; rd_e = 0; pc_src_e = 1;
        #2 ctl("br.c2", 0, 1, 1);
        next_cyc();
        pc_src_e = 0; rs2_d = 0;
        #2 ctl("br.c3", 0, 0, 0);
        chk("br.count", stall_count, 32'd4);

        // scoreboard set / hold / retire
        next_cyc();
        long_issue_e = 1; rd_e = 9;
        #2 ctl("sb.issue", 0, 0, 0);
        next_cyc();
        long_issue_e = 0; rd_e = 0; rs1_d = 9;
        #2 chk("sb.stall", 32'(stall_d), 32'd1);
        chk("sb.busy", 32'(sb_busy), 32'd1);
        next_cyc();
        long_done = 1; long_done_rd = 9;
        #2 chk("sb.no_bypass", 32'(stall_d), 32'd1);
        next_cyc();
        long_done = 0;
        #2 chk("sb.retired", 32'(stall_d), 32'd0);
        chk("sb.idle", 32'(sb_busy), 32'd0);
        chk("sb.count", stall_count, 32'd6);
        rs1_d = 0;

        // same-cycle set and clear, set wins
        next_cyc();
        long_issue_e = 1; rd_e = 4;
        next_cyc();
        long_done = 1; long_done_rd = 4;
        #2 chk("sc.set", 32'(sb_busy), 32'd1);
        next_cyc();
        long_issue_e = 0; long_done = 0; rd_e = 0; rs2_d = 4;
        #2 chk("sc.kept", 32'(sb_busy), 32'd1);
        chk("sc.stall", 32'(stall_d), 32'd1);
        next_cyc();
        rs2_d = 0; long_done = 1; long_done_rd = 4;
        next_cyc();
        long_done = 0;
        #2 chk("sc.clear", 32'(sb_busy), 32'd0);
        // x0 destination and flushed issue never set a bit
        long_issue_e = 1; rd_e = 0;
        next_cyc();
        rd_e = 12; pc_src_e = 1;
        #2 chk("sc.x0", 32'(sb_busy), 32'd0);
        next_cyc();
        idle();
        #2 chk("sc.flushed", 32'(sb_busy), 32'd0);
        chk("sc.count", stall_count, 32'd7);

        // async reset during a load stall
        next_cyc();
        result_src_e = 2'b01; rd_e = 7; rs1_d = 7;
        #2 ctl("ar.pre", 1, 0, 1);
        rst_n = 0;
        #1 ctl("ar.in", 0, 0, 0);
        chk("ar.count", stall_count, 32'd0);
        idle();
        #1 rst_n = 1;
        next_cyc();
        #2 ctl("ar.post", 0, 0, 0);
        next_cyc();
        #2 ctl("ar.post2", 0, 0, 0);
        chk("ar.count2", stall_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
